// File: rtl/dsp_rr_scheduler.sv
// Round-robin issue of two operand streams into one pipelined DSP slice
// computing P = A*(D+B) +/- C, with C alignment and ID tag tracking.
module dsp_rr_scheduler #(
  parameter int LATENCY = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [17:0]      req0_a,
  input  logic [17:0]      req0_b,
  input  logic [17:0]      req0_d,
  input  logic [47:0]      req0_c,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [17:0]      req1_a,
  input  logic [17:0]      req1_b,
  input  logic [17:0]      req1_d,
  input  logic [47:0]      req1_c,
  input  logic             issue_en,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [17:0]      dsp_d,
  output logic [47:0]      dsp_c,
  input  logic [47:0]      dsp_p,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [47:0]      rsp_p,
  output logic             busy,
  output logic [CNT_W-1:0] issued0_cnt,
  output logic [CNT_W-1:0] issued1_cnt
);

  localparam int FW = $clog2(LATENCY + 3) + 1;

  logic             r_prio;
  logic             w_issue;
  logic             w_id;
  logic [17:0]      w_a;
  logic [17:0]      w_b;
  logic [17:0]      w_d;
  logic [47:0]      w_c;
  logic [17:0]      r_a;
  logic [17:0]      r_b;
  logic [17:0]      r_d;
  logic [47:0]      r_c [0:LATENCY-2];
  logic [LATENCY:0] r_tag_v;
  logic [LATENCY:0] r_tag_id;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [47:0]      r_rsp_p;
  logic [FW-1:0]    r_infl;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  // Grant: prio side wins when both are valid; a lone requester always wins.
  assign req0_ready = issue_en & req0_valid
                    & (~r_prio | ~req1_valid);
  assign req1_ready = issue_en & req1_valid
                    & (r_prio | ~req0_valid);
  assign w_issue = (req0_valid & req0_ready)
                 | (req1_valid & req1_ready);
  assign w_id = req1_valid & req1_ready;

  // Operand select for the granted requester; zeros when idle.
  always_comb begin
    w_a = '0;
    w_b = '0;
    w_d = '0;
    w_c = '0;
    unique case (1'b1)
      (w_issue & ~w_id): begin
        w_a = req0_a;
        w_b = req0_b;
        w_d = req0_d;
        w_c = req0_c;
      end
      (w_issue & w_id): begin
        w_a = req1_a;
        w_b = req1_b;
        w_d = req1_d;
        w_c = req1_c;
      end
      default: ;
    endcase
  end

  // Priority pointer flips to the other side after each issue.
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_prio <= 1'b0;
    else if (w_issue)
      r_prio <= ~w_id;
  end

  // Issue register driving the slice A/B/D ports.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a <= '0;
      r_b <= '0;
      r_d <= '0;
    end else begin
      r_a <= w_a;
      r_b <= w_b;
      r_d <= w_d;
    end
  end

  // C delay line: tail lines up with the slice post-adder stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i <= LATENCY - 2; i++)
        r_c[i] <= '0;
    end else begin
      r_c[0] <= w_c;
      for (int i = 1; i <= LATENCY - 2; i++)
        r_c[i] <= r_c[i-1];
    end
  end

  // Tag shift register follows each issue through the slice.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tag_v  <= '0;
      r_tag_id <= '0;
    end else begin
      r_tag_v  <= {r_tag_v[LATENCY-1:0], w_issue};
      r_tag_id <= {r_tag_id[LATENCY-1:0], w_id};
    end
  end

  // Response capture when a tag reaches the tail; data holds otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_p     <= '0;
    end else begin
      r_rsp_valid <= r_tag_v[LATENCY];
      if (r_tag_v[LATENCY]) begin
        r_rsp_id <= r_tag_id[LATENCY];
        r_rsp_p  <= dsp_p;
      end
    end
  end

  // In-flight count: up on issue, down on response strobe.
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_infl <= '0;
    else begin
      unique case ({w_issue, r_rsp_valid})
        2'b10:   r_infl <= r_infl + 1'b1;
        2'b01:   r_infl <= r_infl - 1'b1;
        default: r_infl <= r_infl;
      endcase
    end
  end

  // Per-requester saturating issue counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_issue && !w_id && r_cnt0 != '1)
        r_cnt0 <= r_cnt0 + 1'b1;
      if (w_issue && w_id && r_cnt1 != '1)
        r_cnt1 <= r_cnt1 + 1'b1;
    end
  end

  assign dsp_a       = r_a;
  assign dsp_b       = r_b;
  assign dsp_d       = r_d;
  assign dsp_c       = r_c[LATENCY-2];
  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_rsp_id;
  assign rsp_p       = r_rsp_p;
  assign busy        = (r_infl != '0);
  assign issued0_cnt = r_cnt0;
  assign issued1_cnt = r_cnt1;

endmodule
